id_ex_decode_stage: RTL and testbench
=====================================

Name: id_ex_decode_stage

Overview:
- Decode stage plus ID/EX pipeline register for the 5-stage RV32I core.
- Producer end of the ALU interface: turns IF/ID instructions into the 4-bit aluop, the immediate, and the operand selects consumed by EX.
- Holds results in a registered stage with valid/ready stall and flush.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  IF/ID holds an instruction
- if_inst  in  32  instruction word
- if_pc  in  32  instruction PC
- id_ready  out  1  stage accepts if_inst this cycle
- flush  in  1  kill the stage contents (branch/trap)
- ex_ready  in  1  EX accepts the current ID/EX contents
- ex_valid  out  1  ID/EX contents are valid
- ex_aluop  out  4  ALU operation code
- ex_imm  out  32  decoded immediate
- ex_sel_a  out  1  operand A: 0 = rs1, 1 = pc
- ex_sel_b  out  1  operand B: 0 = rs2, 1 = imm
- ex_rs1, ex_rs2, ex_rd  out  5 each  register indices
- ex_reg_we  out  1  writeback enable
- ex_mem_rd, ex_mem_wr  out  1 each  load / store
- ex_pc  out  32  registered PC
- ex_illegal  out  1  unsupported encoding

Behaviour:
- Reset: all outputs 0.
- Reset is asynchronous and active-high; asserting rst mid-operation drops ex_valid immediately.
- id_ready = !ex_valid || ex_ready. It is combinational and has no dependency on if_valid.
- Load: if_valid && id_ready registers the decoded fields and sets ex_valid = 1 on the next edge. Latency is 1 cycle.
- Drain: ex_valid && ex_ready && !(if_valid && id_ready) sets ex_valid = 0. The payload is held and not cleared.
- Stall: ex_valid && !ex_ready holds every ex_* output stable.
- Flush: has priority over load and stall. Next edge ex_valid = 0, ex_reg_we = 0, ex_mem_rd = 0, ex_mem_wr = 0.
- aluop encoding:
  - ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100
  - XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001
  - MUL 1011, LUI 1100, AUIPC 1101
- OP (0110011):
  - Decode on funct3. funct7 = 0100000 selects SUB for f3 = 000 and SRA for f3 = 101.
  - sel_b = 0, reg_we = 1.
  - Any other funct7 → illegal.
- OP-IMM (0010011):
  - imm is I-type, sign-extended.
  - SLLI/SRLI/SRAI: imm = {27'b0, inst[24:20]}; inst[30] selects SRAI.
  - No SUBI.
  - sel_b = 1, reg_we = 1.
- LUI (0110111):
  - aluop 1100, imm = {12'b0, inst[31:12]}, which EX shifts by 12.
  - reg_we = 1.
- AUIPC (0010111):
  - aluop 1101, sel_a = 1, sel_b = 1.
  - imm is the same as LUI.
  - reg_we = 1.
- LOAD (0000011): ADD, I-imm, sel_b = 1, mem_rd = 1, reg_we = 1.
- STORE (0100011): ADD, S-imm, sel_b = 1, mem_wr = 1, reg_we = 0.
- Any other opcode, or illegal funct:
  - ex_illegal = 1, aluop 0000.
  - reg_we = 0, mem_rd = 0, mem_wr = 0.
  - The stage still loads and remains valid.
- rd = x0: reg_we is still asserted; the register file ignores writes to x0.

Optional Feature:
- RV32M_MUL_EN defined: OP with funct7 = 0000001, f3 = 000 decodes to aluop 1011, reg_we = 1.
- RV32M_MUL_EN undefined: the same encoding → ex_illegal = 1.
- Other funct3 values with funct7 = 0000001 are illegal in both builds.

Decomposition:
- Shared package core_pkg holds:
  - the aluop_e enum with the codes above;
  - the opcode localparams;
  - the funct7 constants;
  - a decoded-fields struct.
- Sub-module aluop_decoder is purely combinational: inst in, decoded struct out.
- id_ex_decode_stage contains only the handshake logic and the register.

Test Plan:
- 0x00500093 (ADDI x1, x0, 5) → aluop 0000, imm 5, sel_b 1, rd 1, reg_we 1, ex_valid one cycle later.
- 0x402081B3 (SUB x3, x1, x2) → aluop 0001, sel_b 0, rs1 1, rs2 2, rd 3.
- 0x123452B7 (LUI x5) → aluop 1100, imm 0x00012345.
- 0x4030D213 (SRAI x4, x1, 3) → aluop 0111, imm 3.
- 0x02208333 (MUL x6, x1, x2) → aluop 1011 with RV32M_MUL_EN, ex_illegal 1 without it.
- Hold ex_ready = 0 for 3 cycles with new if_inst → outputs frozen, id_ready 0.
- Assert flush together with a load → ex_valid 0 next cycle.
- Assert rst mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared decode definitions for the RV32I core: ALU op codes, opcode/funct7
// constants and the decoded-fields record passed from ID to EX.
package core_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_MUL   = 4'b1011,
        ALU_LUI   = 4'b1100,
        ALU_AUIPC = 4'b1101
    } aluop_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        aluop_e      aluop;
        logic [31:0] imm;
        logic        sel_a;
        logic        sel_b;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
    } decoded_t;

    // funct3 -> ALU op shared by OP and OP-IMM; 101 yields SRL, callers upgrade to SRA.
    function automatic aluop_e base_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_decode_stage_if.sv
// IF/ID -> ID/EX bundle. master = upstream fetch/EX side, slave = the decode stage.
interface id_ex_decode_stage_if;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [3:0]  ex_aluop;
    logic [31:0] ex_imm;
    logic        ex_sel_a;
    logic        ex_sel_b;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [31:0] ex_pc;
    logic        ex_illegal;

    modport master (
        output if_valid, if_inst, if_pc, flush, ex_ready,
        input  id_ready, ex_valid, ex_aluop, ex_imm, ex_sel_a, ex_sel_b,
               ex_rs1, ex_rs2, ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr,
               ex_pc, ex_illegal
    );

    modport slave (
        input  if_valid, if_inst, if_pc, flush, ex_ready,
        output id_ready, ex_valid, ex_aluop, ex_imm, ex_sel_a, ex_sel_b,
               ex_rs1, ex_rs2, ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr,
               ex_pc, ex_illegal
    );
endinterface

// File: rtl/id_ex_decode_stage_aluop_decoder.sv
// Combinational RV32I instruction decoder. Define RV32M_MUL_EN to accept MUL
// (funct7 0000001, funct3 000); otherwise that encoding is reported illegal.
module aluop_decoder
    import core_pkg::*;
(
    input  logic [31:0] inst,
    output decoded_t    dec
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] imm_sh;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    // U-immediate stays unshifted; EX applies the <<12.
    assign imm_u  = {12'b0, inst[31:12]};
    assign imm_sh = {27'b0, inst[24:20]};

    always_comb begin
        dec     = '0;
        dec.rs1 = inst[19:15];
        dec.rs2 = inst[24:20];
        dec.rd  = inst[11:7];
        case (opcode)
            OPC_OP: begin
                dec.reg_we = 1'b1;
                if (funct7 == F7_BASE)
                    dec.aluop = base_op(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000)
                    dec.aluop = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101)
                    dec.aluop = ALU_SRA;
`ifdef RV32M_MUL_EN
                else if (funct7 == F7_MULDIV && funct3 == 3'b000)
                    dec.aluop = ALU_MUL;
`endif
                else begin
                    dec.illegal = 1'b1;
                    dec.reg_we  = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec.sel_b  = 1'b1;
                dec.reg_we = 1'b1;
                dec.aluop  = base_op(funct3);
                dec.imm    = (funct3 == 3'b001 || funct3 == 3'b101) ? imm_sh : imm_i;
                if (funct3 == 3'b101 && inst[30])
                    dec.aluop = ALU_SRA;
            end
            OPC_LUI: begin
                dec.aluop  = ALU_LUI;
                dec.imm    = imm_u;
                dec.sel_b  = 1'b1;
                dec.reg_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec.aluop  = ALU_AUIPC;
                dec.imm    = imm_u;
                dec.sel_a  = 1'b1;
                dec.sel_b  = 1'b1;
                dec.reg_we = 1'b1;
            end
            OPC_LOAD: begin
                dec.imm    = imm_i;
                dec.sel_b  = 1'b1;
                dec.mem_rd = 1'b1;
                dec.reg_we = 1'b1;
            end
            OPC_STORE: begin
                dec.imm    = imm_s;
                dec.sel_b  = 1'b1;
                dec.mem_wr = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_decode_stage.sv
// Decode stage and ID/EX pipeline register with valid/ready stall and flush.
// Optional MUL decode is enabled by defining RV32M_MUL_EN (see aluop_decoder).
module id_ex_decode_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    id_ex_decode_stage_if.slave  bus
);

    decoded_t        dec;
    decoded_t        stage_q;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            load;

    aluop_decoder u_dec (
        .inst (bus.if_inst),
        .dec  (dec)
    );

    // Handshake: a word moves across a boundary on a clock edge where both its
    // valid and ready are high. The stage is ready whenever it is empty or EX is
    // taking the current contents this cycle; ready never looks at if_valid.
    assign bus.id_ready = !valid_q || bus.ex_ready;
    assign load         = bus.if_valid && bus.id_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            stage_q <= '0;
            pc_q    <= '0;
        end else if (bus.flush) begin
            // Kill side effects only; the rest of the payload is left as-is.
            valid_q        <= 1'b0;
            stage_q.reg_we <= 1'b0;
            stage_q.mem_rd <= 1'b0;
            stage_q.mem_wr <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            stage_q <= dec;
            pc_q    <= bus.if_pc;
        end else if (bus.ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.ex_valid   = valid_q;
    assign bus.ex_aluop   = stage_q.aluop;
    assign bus.ex_imm     = stage_q.imm;
    assign bus.ex_sel_a   = stage_q.sel_a;
    assign bus.ex_sel_b   = stage_q.sel_b;
    assign bus.ex_rs1     = stage_q.rs1;
    assign bus.ex_rs2     = stage_q.rs2;
    assign bus.ex_rd      = stage_q.rd;
    assign bus.ex_reg_we  = stage_q.reg_we;
    assign bus.ex_mem_rd  = stage_q.mem_rd;
    assign bus.ex_mem_wr  = stage_q.mem_wr;
    assign bus.ex_pc      = pc_q;
    assign bus.ex_illegal = stage_q.illegal;

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Scoreboard bench for id_ex_decode_stage: directed cases plus randomized
// traffic checked against an instruction-level reference model.
module tb_id_ex_decode_stage;

    localparam int W = 89;
`ifdef RV32M_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_decode_stage_if bus ();

    id_ex_decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] prev_out;
    bit prev_stall = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {aluop, imm, sel_a, sel_b, rs1, rs2, rd, reg_we, mem_rd, mem_wr, pc, illegal}
    function automatic logic [W-1:0] dut_out();
        return {bus.ex_aluop, bus.ex_imm, bus.ex_sel_a, bus.ex_sel_b, bus.ex_rs1,
                bus.ex_rs2, bus.ex_rd, bus.ex_reg_we, bus.ex_mem_rd, bus.ex_mem_wr,
                bus.ex_pc, bus.ex_illegal};
    endfunction

    // Reference decode from the ISA rules, as numbers.
    function automatic logic [W-1:0] model(input logic [31:0] inst, input logic [31:0] pc);
        int op = int'(inst[6:0]);
        int f3 = int'(inst[14:12]);
        int f7 = int'(inst[31:25]);
        int i_imm = int'($signed(inst[31:20]));
        int s_imm = int'($signed({inst[31:25], inst[11:7]}));
        int u_imm = int'(inst[31:12]);
        int by_f3[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int aluop = 0;
        int imm = 0;
        bit sa = 0, sb = 0, we = 0, mr = 0, mw = 0, ill = 0;
        case (op)
            'h33: begin
                if (f7 == 0) begin aluop = by_f3[f3]; we = 1; end
                else if (f7 == 'h20 && f3 == 0) begin aluop = 1; we = 1; end
                else if (f7 == 'h20 && f3 == 5) begin aluop = 7; we = 1; end
                else if (f7 == 1 && f3 == 0 && MUL_EN) begin aluop = 11; we = 1; end
                else ill = 1;
            end
            'h13: begin
                sb = 1; we = 1; aluop = by_f3[f3]; imm = i_imm;
                if (f3 == 1 || f3 == 5) imm = int'(inst[24:20]);
                if (f3 == 5 && inst[30]) aluop = 7;
            end
            'h37: begin aluop = 12; imm = u_imm; sb = 1; we = 1; end
            'h17: begin aluop = 13; imm = u_imm; sa = 1; sb = 1; we = 1; end
            'h03: begin imm = i_imm; sb = 1; mr = 1; we = 1; end
            'h23: begin imm = s_imm; sb = 1; mw = 1; end
            default: ill = 1;
        endcase
        return {aluop[3:0], imm[31:0], sa, sb, inst[19:15], inst[24:20], inst[11:7],
                we, mr, mw, pc, ill};
    endfunction

    // Monitor: check hold during stall, pop on every transfer, push on every load.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("id_ready_rule", W'(bus.id_ready), W'(!bus.ex_valid || bus.ex_ready));
            if (prev_stall) begin
                check("stall_hold", dut_out(), prev_out);
                check("stall_valid", W'(bus.ex_valid), W'(1));
            end
            if (bus.ex_valid && bus.ex_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_transfer: got %h expected none", dut_out());
                end else begin
                    check("transfer", dut_out(), exp_q.pop_front());
                end
            end else if (bus.ex_valid && bus.flush && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            if (bus.if_valid && bus.id_ready && !bus.flush)
                exp_q.push_back(model(bus.if_inst, bus.if_pc));
            prev_stall = bus.ex_valid && !bus.ex_ready && !bus.flush;
            prev_out   = dut_out();
        end
    end

    task automatic send_check(input string name, input logic [31:0] inst, input logic [31:0] pc,
                              input logic [3:0] exp_op, input logic [31:0] exp_imm);
        @(posedge clk); #1;
        bus.if_valid = 1'b1; bus.if_inst = inst; bus.if_pc = pc;
        bus.ex_ready = 1'b1; bus.flush = 1'b0;
        @(posedge clk); #1;
        bus.if_valid = 1'b0;
        check({name, "_valid"}, W'(bus.ex_valid), W'(1));
        check({name, "_aluop"}, W'(bus.ex_aluop), W'(exp_op));
        check({name, "_imm"}, W'(bus.ex_imm), W'(exp_imm));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] inst = $urandom;
        logic [6:0] ops[7] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h00};
        logic [6:0] f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h7f};
        int k = $urandom_range(0, 6);
        inst[6:0] = (k == 6) ? 7'($urandom) : ops[k];
        if (k == 0) inst[31:25] = f7s[$urandom_range(0, 3)];
        return inst;
    endfunction

    initial begin
        logic [W-1:0] snap;
        rst = 1'b1;
        bus.if_valid = 1'b0; bus.if_inst = '0; bus.if_pc = '0;
        bus.flush = 1'b0; bus.ex_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", dut_out(), '0);
        check("reset_valid", W'(bus.ex_valid), W'(0));
        check("reset_id_ready", W'(bus.id_ready), W'(1));
        rst = 1'b0;

        send_check("addi", 32'h00500093, 32'h0000_1000, 4'b0000, 32'd5);
        check("addi_selb_rd_we", W'({bus.ex_sel_b, bus.ex_rd, bus.ex_reg_we}), W'({1'b1, 5'd1, 1'b1}));
        send_check("sub", 32'h402081B3, 32'h0000_1004, 4'b0001, 32'd0);
        check("sub_regs", W'({bus.ex_sel_b, bus.ex_rs1, bus.ex_rs2, bus.ex_rd}),
              W'({1'b0, 5'd1, 5'd2, 5'd3}));
        send_check("lui", 32'h123452B7, 32'h0000_1008, 4'b1100, 32'h0001_2345);
        send_check("srai", 32'h4030D213, 32'h0000_100C, 4'b0111, 32'd3);
        send_check("mul", 32'h02208333, 32'h0000_1010, MUL_EN ? 4'b1011 : 4'b0000, 32'd0);
        check("mul_illegal", W'(bus.ex_illegal), W'(!MUL_EN));

        // Stall: new instruction offered while EX is blocked for 3 cycles.
        @(posedge clk); #1;
        bus.if_valid = 1'b1; bus.if_inst = 32'h00500093; bus.if_pc = 32'h2000; bus.ex_ready = 1'b0;
        @(posedge clk); #1;
        bus.if_inst = 32'h402081B3; bus.if_pc = 32'h2004;
        snap = dut_out();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_id_ready", W'(bus.id_ready), W'(0));
            check("stall_frozen", dut_out(), snap);
            @(posedge clk); #1;
        end
        bus.ex_ready = 1'b1;
        @(posedge clk); #1;
        check("after_stall_sub", W'(bus.ex_aluop), W'(4'b0001));

        // Flush together with a load.
        bus.if_inst = 32'h00500093; bus.if_pc = 32'h2008; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.if_valid = 1'b0;
        check("flush_load_valid", W'(bus.ex_valid), W'(0));

        // Flush of a stalled load clears side effects.
        bus.if_valid = 1'b1; bus.if_inst = 32'h0040A103; bus.if_pc = 32'h200C; bus.ex_ready = 1'b0;
        @(posedge clk); #1;
        bus.if_valid = 1'b0; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_side_effects",
              W'({bus.ex_valid, bus.ex_reg_we, bus.ex_mem_rd, bus.ex_mem_wr}), W'(0));

        // Asynchronous reset in the middle of a stall.
        bus.if_valid = 1'b1; bus.if_inst = 32'h00500093; bus.if_pc = 32'h2010;
        @(posedge clk); #1;
        bus.if_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out", dut_out(), '0);
        check("rst_mid_valid", W'(bus.ex_valid), W'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            bus.ex_ready = ($urandom_range(0, 3) != 0);
            bus.flush    = ($urandom_range(0, 19) == 0);
            bus.if_valid = ($urandom_range(0, 3) != 0);
            bus.if_inst  = rand_inst();
            bus.if_pc    = $urandom & 32'hFFFF_FFFC;
        end

        @(posedge clk); #1;
        bus.if_valid = 1'b0; bus.flush = 1'b0; bus.ex_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_empty", W'(exp_q.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
